// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : score_pkg
//  Purpose  : Shared constants and state encoding for the score display path.
//  Revision : 1.0  initial release
// ============================================================================
package score_pkg;

    localparam int SCORE_W      = 20;
    localparam int SCORE_DIGITS = 6;
    localparam int SCORE_MAX    = 999999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Largest displayable value plus one for a given digit count.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_add3
//  Purpose  : Double-dabble digit correction, adds 3 to digits of 5 or more.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule
`default_nettype wire

// File: rtl/score_bcd_conv.sv
`default_nettype none
// ============================================================================
//  Module   : score_bcd_conv
//  Purpose  : Sequential binary-to-BCD converter (one bit per clock) with
//             saturation to the display range and an overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
module score_bcd_conv
    import score_pkg::*;
#(
    parameter int BIN_W  = SCORE_W,
    parameter int DIGITS = SCORE_DIGITS
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int          ACC_W     = 4 * DIGITS;
    localparam int          CNT_W     = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [63:0] C_MAX     = pow10(DIGITS) - 64'd1;
    localparam logic [BIN_W-1:0] C_MAX_BIN = C_MAX[BIN_W-1:0];
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BIN_W - 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [BIN_W-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_next_q, ovf_next_d;
    logic [ACC_W-1:0]   bcd_out_q;
    logic               busy_q, done_q, ovf_q;

    logic [ACC_W-1:0]   w_acc_adj;
    logic               w_ovr;

    assign w_ovr = (64'(bin_in) > C_MAX);

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (acc_q[4*gi +: 4]),
            .digit_o (w_acc_adj[4*gi +: 4])
        );
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        ovf_next_d = ovf_next_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_d       = w_ovr ? C_MAX_BIN : bin_in;
                    ovf_next_d = w_ovr;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Correct digits first, then shift the combined register left.
                {acc_d, sh_d} = {w_acc_adj, sh_q} << 1;
                cnt_d         = cnt_q + CNT_W'(1);
                if (cnt_q == C_CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            sh_q       <= '0;
            cnt_q      <= '0;
            ovf_next_q <= 1'b0;
            bcd_out_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            ovf_next_q <= ovf_next_d;
            // Outputs trail the state by one cycle so busy spans the done pulse.
            busy_q     <= (state_q != ST_IDLE);
            done_q     <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                bcd_out_q <= acc_q;
                ovf_q     <= ovf_next_q;
            end
        end
    end

    assign bcd_out = bcd_out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_conv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_bcd_conv
//  Purpose  : Self-checking bench for score_bcd_conv with a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_score_bcd_conv;

    typedef struct {
        logic [23:0] bcd;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [19:0] bin_in;
    logic        start;
    logic [23:0] bcd_out;
    logic        busy;
    logic        done;
    logic        ovf;

    int   checks;
    int   failures;
    int   done_cnt;
    exp_t sb[$];
    exp_t mon_e;

    score_bcd_conv dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bin_in    (bin_in),
        .start     (start),
        .bcd_out   (bcd_out),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        int unsigned x;
        e.ovf = (v > 999999);
        x     = e.ovf ? 999999 : v;
        e.bcd = '0;
        for (int d = 0; d < 6; d++) begin
            e.bcd[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_cnt = done_cnt + 1;
            checks   = checks + 1;
            if (sb.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_done: got bcd=%h ovf=%b, required no done", bcd_out, ovf);
            end else begin
                mon_e = sb.pop_front();
                if (bcd_out !== mon_e.bcd || ovf !== mon_e.ovf) begin
                    failures = failures + 1;
                    $display("FAIL result: got bcd=%h ovf=%b, required bcd=%h ovf=%b",
                             bcd_out, ovf, mon_e.bcd, mon_e.ovf);
                end
            end
        end
    end

    // Leaves the caller just after the acceptance edge with start low.
    task automatic pulse_start(input logic [19:0] v, input bit expect_result);
        @(posedge clk);
        #1;
        bin_in = v;
        start  = 1'b1;
        if (expect_result) sb.push_back(model(32'(v)));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != c0) break;
        end
        checks = checks + 1;
        if (done_cnt == c0) begin
            failures = failures + 1;
            $display("FAIL done_timeout: got no done in %0d cycles, required one", budget);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (bcd_out !== 24'h0) begin failures++; $display("FAIL reset_bcd: got %h required 000000", bcd_out); end
        checks = checks + 1;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks = checks + 1;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", done); end
        checks = checks + 1;
        if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b required 0", ovf); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency();
        int first_done;
        int busy_cycles;
        first_done  = -1;
        busy_cycles = 0;
        pulse_start(20'd0, 1'b1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1 && first_done < 0) first_done = k;
        end
        checks = checks + 1;
        if (first_done != 21) begin failures++; $display("FAIL latency: got %0d required 21", first_done); end
        checks = checks + 1;
        if (busy_cycles != 21) begin failures++; $display("FAIL busy_len: got %0d required 21", busy_cycles); end
    endtask

    task automatic test_values();
        logic [19:0] vals [6];
        int c0;
        vals = '{20'd123456, 20'd999999, 20'd10, 20'hFFFFF, 20'd7, 20'd1000000};
        foreach (vals[i]) begin
            c0 = done_cnt;
            pulse_start(vals[i], 1'b1);
            wait_done(c0, 30);
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int c0;
        c0 = done_cnt;
        pulse_start(20'd42, 1'b1);
        repeat (3) @(posedge clk);
        #1 bin_in = 20'd500;
        @(posedge clk);
        #1;
        bin_in = 20'd77;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (45) @(posedge clk);
        checks = checks + 1;
        if (done_cnt - c0 != 1) begin
            failures++;
            $display("FAIL ignore_start: got %0d dones required 1", done_cnt - c0);
        end
    endtask

    task automatic test_back_to_back();
        int t[$];
        @(posedge clk);
        #1;
        bin_in = 20'd5;
        start  = 1'b1;
        repeat (3) sb.push_back(model(32'd5));
        @(posedge clk);
        #1;
        for (int k = 0; k < 72; k++) begin
            @(negedge clk);
            if (done === 1'b1) t.push_back(k);
            if (k == 50) start = 1'b0;
        end
        checks = checks + 1;
        if (t.size() != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d dones required 3", t.size());
        end else begin
            checks = checks + 1;
            if (t[0] != 21) begin failures++; $display("FAIL b2b_first: got %0d required 21", t[0]); end
            checks = checks + 1;
            if (t[1] - t[0] != 22) begin failures++; $display("FAIL b2b_gap1: got %0d required 22", t[1] - t[0]); end
            checks = checks + 1;
            if (t[2] - t[1] != 22) begin failures++; $display("FAIL b2b_gap2: got %0d required 22", t[2] - t[1]); end
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        c0 = done_cnt;
        pulse_start(20'd654321, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks = checks + 1;
        if (bcd_out !== 24'h0) begin failures++; $display("FAIL midrst_bcd: got %h required 000000", bcd_out); end
        checks = checks + 1;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", busy); end
        checks = checks + 1;
        if (done !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL midrst_flags: got done=%b ovf=%b required 0 0", done, ovf);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks = checks + 1;
        if (done_cnt != c0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_resume: got dones=%0d busy=%b required 0 0", done_cnt - c0, busy);
        end
        c0 = done_cnt;
        pulse_start(20'd654321, 1'b1);
        wait_done(c0, 30);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        bin_in   = '0;
        test_reset();
        test_latency();
        test_values();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        checks = checks + 1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending results required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/score_bcd_conv.md
# score_bcd_conv

Sequential binary-to-BCD converter on the score path, directly upstream of the seven-segment driver `top_seg_595`. It takes the game's 20-bit binary score and produces six packed BCD digits using the shift-and-add-3 (double-dabble) method, one bit per clock. A start/busy/done handshake replaces the segment driver's combinational divide-by-ten chain. Values above the display range saturate to 999999 and raise an overflow flag.

## Interface
- `BIN_W`, 20, width of the binary input.
- `DIGITS`, 6, number of BCD digits produced; the output is `4*DIGITS` bits wide.
- `sys_clk`  in  1  system clock, 50 MHz.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `bin_in`  in  BIN_W  binary score; sampled only in the cycle where `start` is accepted.
- `start`  in  1  single-cycle request; accepted only in IDLE.
- `bcd_out`  out  4*DIGITS  packed BCD, most significant digit in `[23:20]`; held between conversions.
- `busy`  out  1  high from the cycle after acceptance until the done cycle, inclusive.
- `done`  out  1  one-cycle pulse; `bcd_out` and `ovf` are valid in the same cycle.
- `ovf`  out  1  set when the last converted input was greater than 999999.

## Operation
- **States:** IDLE, SHIFT, DONE; 2-bit state register.
- **IDLE:**
  - `start`=1 latches `bin_in` into the shift register.
  - If `bin_in` > 10^DIGITS−1, the register loads 999999 instead and `ovf_next` is set to 1; otherwise `ovf_next` is 0.
  - The BCD accumulator (4*DIGITS bits) is cleared, the bit counter is cleared, and the state goes to SHIFT.
- **SHIFT:** each cycle performs two steps.
  - Every 4-bit accumulator digit that is ≥5 gets +3 (mod 16; the result never exceeds 12).
  - Then {accumulator, shift register} shifts left by 1.
  - The counter increments. When the counter reaches BIN_W−1 and the shift is done, the state goes to DONE. SHIFT lasts exactly BIN_W cycles.
- **DONE:**
  - `bcd_out` ← accumulator, `ovf` ← `ovf_next`, `done`=1 for this one cycle.
  - The state returns to IDLE.
- `start` asserted while in SHIFT or DONE is ignored; it is not queued.
- `start` held high continuously restarts a conversion every BIN_W+2 cycles, each with a fresh `bin_in` sample.
- Changes to `bin_in` after acceptance have no effect on the running conversion.
- **Reset (asserted at any time, including mid-SHIFT):**
  - The state goes to IDLE immediately.
  - `bcd_out`=0, `busy`=0, `done`=0, `ovf`=0.
  - The accumulator, shift register and counter are cleared.
  - There is no partial result; the first conversion after reset needs a new `start`.

## Timing
- Start is accepted at rising edge t0.
- SHIFT covers edges t0+1 … t0+BIN_W; `busy`=1 from t0+1.
- DONE is registered at edge t0+BIN_W+1: `done`=1, `busy` still 1, `bcd_out` updated.
- At edge t0+BIN_W+2 the block is back in IDLE with `busy`=0. A `start` present in that cycle is accepted at that edge.
- Latency from start to done is BIN_W+1 cycles (21 with defaults); throughput is one conversion per BIN_W+2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- **Shared package `score_pkg`:**
  - `SCORE_W`=20, `SCORE_DIGITS`=6.
  - `SCORE_MAX`=999999.
  - State encodings `ST_IDLE`=0, `ST_SHIFT`=1, `ST_DONE`=2.
- **Sub-module `bcd_add3`:** purely combinational, 4-bit in / 4-bit out (in ≥5 ? in+3 : in). It is instantiated DIGITS times in a generate loop.
- **Top-level integration:** `score_bcd_conv` is placed between the game logic's `score` output and `top_seg_595`. The game logic pulses `start` when the score changes.

## Test plan
- Reset released, `bin_in`=0, one `start` pulse → `done` 21 cycles later, `bcd_out`=0x000000, `ovf`=0; `busy` high for exactly 21 cycles.
- `bin_in`=123456 → `bcd_out`=0x123456; `bin_in`=999999 → 0x999999 with `ovf`=0; `bin_in`=10 → 0x000010.
- `bin_in`=1048575 (all ones) → `bcd_out`=0x999999, `ovf`=1; then `bin_in`=7 → 0x000007 and `ovf` back to 0.
- `start` at t0 with 42, second `start` at t0+5 with 77, `bin_in` changed to 500 at t0+3 → a single `done` with 0x000042; no second `done`.
- `start` held high with `bin_in`=5 → `done` pulses every 22 cycles, each with 0x000005.
- `sys_rst_n` pulsed low at t0+10 of a conversion of 654321 → all outputs 0 immediately and no `done`; a new `start` then yields 0x654321.
